// File: rtl/muldiv_pkg.sv
// Shared operation/state types and decode helpers for the iterative
// multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {REM, REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unit: radix-2 shift-add multiply or
// restoring divide on a double-width {hi, lo} accumulator.
module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   cand;
    logic [XLEN-1:0] diff;

    // Multiply: lo holds the remaining multiplier bits, LSB consumed first.
    // Divide: cand never exceeds 2*divisor-1, so one XLEN+1-bit trial suffices.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        cand     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = cand[XLEN-1:0] - operand;
        acc_next = {sum, acc[XLEN-1:1]};
        if (div_mode) begin
            if (cand >= {1'b0, operand}) begin
                acc_next = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {cand[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension multiply/divide unit, one result bit per cycle.
// Define MULDIV_WORD_EN to honour word_i (32-bit *W ops, XLEN=64 only).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  muldiv_op_e      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(XLEN - 1);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  last_cnt;
    muldiv_op_e        op_q;
    logic              word_q;
    logic              neg_q;
    logic              rem_neg_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] step_next;
    logic [XLEN-1:0]   result_q;
    logic              accept;
    logic              word_sel;

    logic [XLEN-1:0]   eff_a, eff_b, mag_a, mag_b, min_val, init_lo;
    logic              sign_a, sign_b, div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_raw, fast_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, res_raw, fix_res;

`ifdef MULDIV_WORD_EN
    assign word_sel = word_i;
    assign last_cnt = word_q ? CNT_W'(31) : LAST_FULL;
`else
    logic unused_word;
    assign unused_word = word_i;
    assign word_sel    = 1'b0;
    assign last_cnt    = LAST_FULL;
`endif

    assign result_o = result_q;

    // Request decode: word ops are widened to XLEN up front so the
    // datapath only ever sees full-width operands.
    always_comb begin
        eff_a   = a_i;
        eff_b   = b_i;
        min_val = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_WORD_EN
        if (word_sel) begin
            eff_a   = is_signed_a(op_i) ? {{(XLEN-32){a_i[31]}}, a_i[31:0]}
                                        : {{(XLEN-32){1'b0}}, a_i[31:0]};
            eff_b   = is_signed_b(op_i) ? {{(XLEN-32){b_i[31]}}, b_i[31:0]}
                                        : {{(XLEN-32){1'b0}}, b_i[31:0]};
            min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
        end
`endif
        sign_a   = is_signed_a(op_i) & eff_a[XLEN-1];
        sign_b   = is_signed_b(op_i) & eff_b[XLEN-1];
        mag_a    = sign_a ? -eff_a : eff_a;
        mag_b    = sign_b ? -eff_b : eff_b;
        div_zero = is_div(op_i) && (eff_b == '0);
        div_ovf  = (op_i == DIV || op_i == REM) && (eff_a == min_val) && (eff_b == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_raw = is_rem(op_i) ? eff_a : '1;
        end else begin
            fast_raw = is_rem(op_i) ? '0 : min_val;
        end
        fast_res = fast_raw;
        init_lo  = mag_a;
`ifdef MULDIV_WORD_EN
        if (word_sel) begin
            fast_res = {{(XLEN-32){fast_raw[31]}}, fast_raw[31:0]};
            if (is_div(op_i)) begin
                init_lo = mag_a << (XLEN - 32);
            end
        end
`endif
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (is_div(op_q)),
        .acc      (acc_q),
        .operand  (opb_q),
        .acc_next (step_next)
    );

    // Result fix-up: restore signs on magnitudes, then pick the half or
    // quotient/remainder the op asks for.
    always_comb begin
        prod = acc_q;
`ifdef MULDIV_WORD_EN
        if (word_q) begin
            prod = acc_q >> (XLEN - 32);
        end
`endif
        if (neg_q) begin
            prod = -prod;
        end
        quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                res_raw = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: res_raw = prod[2*XLEN-1:XLEN];
            DIV, DIVU:          res_raw = quot;
            default:            res_raw = rem;
        endcase
        fix_res = res_raw;
`ifdef MULDIV_WORD_EN
        if (word_q) begin
            fix_res = {{(XLEN-32){res_raw[31]}}, res_raw[31:0]};
        end
`endif
    end

    // Next-state and handshake outputs; flush overrides everything but reset.
    always_comb begin
        state_d = state_q;
        ready_o = (state_q == IDLE) && !rst_i;
        valid_o = (state_q == DONE);
        accept  = valid_i && ready_o && !flush_i;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? DONE : CALC;
            CALC:    if (cnt_q == last_cnt) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            op_q      <= MUL;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        op_q      <= op_i;
                        word_q    <= word_sel;
                        neg_q     <= sign_a ^ sign_b;
                        rem_neg_q <= sign_a;
                        opb_q     <= mag_b;
                        acc_q     <= {{XLEN{1'b0}}, init_lo};
                        if (fast) begin
                            result_q <= fast_res;
                        end
                    end
                end
                CALC: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIXUP: begin
                    result_q <= fix_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic reference model,
// per-cycle result comparison, latency, hold, flush and reset checks.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    muldiv_op_e  op_i = MUL;
    logic        word_i = 1'b0;
    logic [63:0] a_i = '0;
    logic [63:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [63:0] result_o;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .word_i   (word_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference arithmetic for full-width ops.
    function automatic logic [63:0] model64(input muldiv_op_e op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ua, ub;
        logic signed [127:0] sa, sb, p;
        logic [63:0] r;
        ua = {64'd0, a};
        ub = {64'd0, b};
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        r  = '0;
        case (op)
            MUL:    begin p = ua * ub; r = p[63:0]; end
            MULH:   begin p = sa * sb; r = p[127:64]; end
            MULHSU: begin p = sa * $signed(ub); r = p[127:64]; end
            MULHU:  begin p = ua * ub; r = p[127:64]; end
            DIV: begin
                if (b == 0) r = ONES;
                else if (a == MIN64 && b == ONES) r = MIN64;
                else r = $signed(a) / $signed(b);
            end
            DIVU: begin
                if (b == 0) r = ONES;
                else r = a / b;
            end
            REM: begin
                if (b == 0) r = a;
                else if (a == MIN64 && b == ONES) r = 64'd0;
                else r = $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    // Reference arithmetic for *W ops: 32-bit result, sign-extended.
    function automatic logic [63:0] model32(input muldiv_op_e op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] x, y, r;
        logic [63:0] p;
        x = a[31:0];
        y = b[31:0];
        r = '0;
        case (op)
            MUL: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
            DIV: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else r = $signed(x) / $signed(y);
            end
            DIVU: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else r = x / y;
            end
            REM: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(x) % $signed(y);
            end
            REMU: begin
                if (y == 0) r = x;
                else r = x % y;
            end
            default: r = 32'hDEAD_BEEF;
        endcase
        return {{32{r[31]}}, r};
    endfunction

    function automatic int expLatency(input muldiv_op_e op, input logic [63:0] a, input logic [63:0] b, input logic w);
        bit isdiv, sgn, fast;
        isdiv = op inside {DIV, DIVU, REM, REMU};
        sgn   = op inside {DIV, REM};
        if (w) begin
            fast = isdiv && (b[31:0] == 0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF));
            return fast ? 1 : 33;
        end
        fast = isdiv && (b == 0 || (sgn && a == MIN64 && b == ONES));
        return fast ? 1 : 65;
    endfunction

    // Compare process: every cycle a result is presented it must match the
    // oldest outstanding expectation, and the unit must not accept.
    always @(negedge clk) begin
        if (rst_i === 1'b0 && valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected valid_o", 64'(valid_o), 64'd0);
            end else begin
                checkOutput("result_o", result_o, exp_q[0]);
                checkOutput("ready_o in DONE", 64'(ready_o), 64'd0);
                if (ready_i === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic acceptOp(input muldiv_op_e op, input logic [63:0] a, input logic [63:0] b,
                            input logic word, output bit ok);
        int waitc;
        waitc = 0;
        ok = 1'b1;
        while (ready_o !== 1'b1 && waitc < 200) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (ready_o !== 1'b1) begin
            checkOutput("ready_o timeout", 64'(ready_o), 64'd1);
            ok = 1'b0;
            return;
        end
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        word_i  = word;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        op_i    = MULHU;
        a_i     = {$urandom, $urandom};
        b_i     = {$urandom, $urandom};
        word_i  = ~word;
    endtask

    task automatic applyStimulus(input muldiv_op_e op, input logic [63:0] a, input logic [63:0] b,
                                 input logic word, input int hold, input logic [63:0] hand);
        logic [63:0] expv;
        logic w;
        int lat;
        bit ok;
        w = word;
`ifndef MULDIV_WORD_EN
        w = 1'b0;
`endif
        expv = w ? model32(op, a, b) : model64(op, a, b);
        checkOutput($sformatf("model %s", op.name()), expv, hand);
        acceptOp(op, a, b, word, ok);
        if (!ok) return;
        exp_q.push_back(expv);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid_o === 1'b1) break;
        end
        checkOutput($sformatf("latency %s", op.name()), 64'(lat), 64'(expLatency(op, a, b, w)));
        if (valid_o !== 1'b1) begin
            exp_q.delete();
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        checkOutput("ready_o after handshake", 64'(ready_o), 64'd1);
        checkOutput("valid_o after handshake", 64'(valid_o), 64'd0);
    endtask

    task automatic watchNoValid(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (valid_o === 1'b1) seen = 1'b1;
        end
        checkOutput(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;

        $display("[TB] reset");
        #1;
        checkOutput("ready_o during reset", 64'(ready_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset valid_o", 64'(valid_o), 64'd0);
        checkOutput("reset result_o", result_o, 64'd0);
        checkOutput("reset ready_o", 64'(ready_o), 64'd0);
        rst_i = 1'b0;
        #1;
        checkOutput("ready_o after reset", 64'(ready_o), 64'd1);

        $display("[TB] multiply");
        applyStimulus(MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 10, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus(MULHU,  ONES, ONES, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(MULHSU, ONES, 64'd2, 1'b0, 2, ONES);
        applyStimulus(MULH,   64'h4000_0000_0000_0000, 64'd4, 1'b0, 0, 64'd1);
        applyStimulus(MULH,   ONES, ONES, 1'b0, 0, 64'd0);

        $display("[TB] divide");
        applyStimulus(DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 3, ONES);
        applyStimulus(DIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 64'd1);
        applyStimulus(DIVU, 64'd100, 64'd7, 1'b0, 0, 64'd14);
        applyStimulus(REMU, 64'd100, 64'd7, 1'b0, 0, 64'd2);
        applyStimulus(DIVU, ONES, 64'd1, 1'b0, 0, ONES);

        $display("[TB] fast paths");
        applyStimulus(DIVU, 64'd5, 64'd0, 1'b0, 0, ONES);
        applyStimulus(REMU, 64'd5, 64'd0, 1'b0, 4, 64'd5);
        applyStimulus(DIV,  64'd5, 64'd0, 1'b0, 0, ONES);
        applyStimulus(REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFF9);
        applyStimulus(DIV,  MIN64, ONES, 1'b0, 0, MIN64);
        applyStimulus(REM,  MIN64, ONES, 1'b0, 0, 64'd0);

`ifdef MULDIV_WORD_EN
        $display("[TB] word ops");
        applyStimulus(MUL, 64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(DIV, 64'd9, 64'hABCD_0000_0000_0000, 1'b1, 0, ONES);
        applyStimulus(DIV, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(REM, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 0, 64'd0);
`else
        $display("[TB] word_i ignored");
        applyStimulus(MUL, 64'h0000_0001_0000_0001, 64'd3, 1'b1, 0, 64'h0000_0003_0000_0003);
`endif

        $display("[TB] flush mid-calc");
        acceptOp(MUL, 64'd3, 64'd5, 1'b0, ok);
        if (ok) begin
            repeat (20) @(posedge clk);
            #1;
            flush_i = 1'b1;
            @(posedge clk);
            #1;
            flush_i = 1'b0;
            checkOutput("ready_o after flush", 64'(ready_o), 64'd1);
            checkOutput("valid_o after flush", 64'(valid_o), 64'd0);
            watchNoValid("valid_o rose after flush", 80);
        end

        $display("[TB] flush with accept");
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = DIVU;
        a_i     = 64'd10;
        b_i     = 64'd0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        checkOutput("ready_o after flushed accept", 64'(ready_o), 64'd1);
        watchNoValid("valid_o rose after flushed accept", 70);

        $display("[TB] reset mid-calc");
        acceptOp(DIVU, 64'd1000, 64'd7, 1'b0, ok);
        if (ok) begin
            repeat (30) @(posedge clk);
            #1;
            rst_i = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("ready_o in reset cycle", 64'(ready_o), 64'd0);
            checkOutput("valid_o in reset cycle", 64'(valid_o), 64'd0);
            rst_i = 1'b0;
            #1;
            checkOutput("ready_o after mid-calc reset", 64'(ready_o), 64'd1);
            checkOutput("result_o after mid-calc reset", result_o, 64'd0);
            watchNoValid("valid_o rose after reset", 80);
        end

        applyStimulus(MUL, 64'd6, 64'd7, 1'b0, 0, 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
